// File: rtl/vector_packer_if.sv
// Byte-element in / packed-vector out handshake bundle for vector_packer.
// Each side of the packer uses valid/ready.
interface vector_packer_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANE_W-1:0]           in_data;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*LANE_W-1:0]     out_vec;
    logic [LANES-1:0]            out_mask;
    logic [$clog2(LANES):0]      out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vec, out_mask, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vec, out_mask, out_count
    );
endinterface

// File: rtl/vector_packer.sv
// Packs a stream of byte elements into one vector register value.
// Element k lands in lane k; in_last closes a short vector early.
module vector_packer #(
    parameter int LANES  = 8,
    parameter int LANE_W = 8
) (
    input logic           clk,
    input logic           rst,
    vector_packer_if.slave bus
);
    localparam int IW = $clog2(LANES);
    localparam int CW = IW + 1;
    localparam int VW = LANES * LANE_W;

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_n;
    logic [VW-1:0]    vec;
    logic [VW-1:0]    vec_n;
    logic [LANES-1:0] mask;
    logic [LANES-1:0] mask_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             rdy;
    logic             vld;
    logic             accept;
    logic             final_el;

    // Handshake outputs depend only on state and rst, never on peer strobes.
    assign rdy = (state == FILL) && !rst;
    assign vld = (state == HOLD) && !rst;

    assign accept   = bus.in_valid && rdy;
    assign final_el = (idx == IW'(LANES - 1)) || bus.in_last;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        vec_n   = vec;
        mask_n  = mask;
        cnt_n   = cnt;
        unique case (state)
            FILL: begin
                if (accept) begin
                    vec_n[int'(idx)*LANE_W +: LANE_W] = bus.in_data;
                    mask_n[idx] = 1'b1;
                    cnt_n       = CW'(idx) + CW'(1);
                    if (final_el) begin
                        state_n = HOLD;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (vld && bus.out_ready) begin
                    state_n = FILL;
                    vec_n   = '0;
                    mask_n  = '0;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= '0;
            vec   <= '0;
            mask  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            vec   <= vec_n;
            mask  <= mask_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_vec   = vec;
    assign bus.out_mask  = mask;
    assign bus.out_count = cnt;
endmodule

// File: tb/tb_vector_packer.sv
// Directed bench for vector_packer with a queue of expected vectors.
// Outputs are sampled 1ns after each rising edge.
module tb_vector_packer;
    typedef struct {
        logic [63:0] vec;
        logic [7:0]  mask;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    logic [7:0] elems [8];
    int   n = 0;
    logic [63:0] hold_vec;

    vector_packer_if #(.LANES(8), .LANE_W(8)) ifc ();

    vector_packer #(.LANES(8), .LANE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: collect elements; a completed vector is pushed on its final accept.
    task automatic model_push(input logic [7:0] d, input logic last);
        exp_t e;
        elems[n] = d;
        n++;
        if (n == 8 || last) begin
            e.vec  = '0;
            e.mask = '0;
            for (int k = 0; k < n; k++) begin
                e.vec[k*8 +: 8] = elems[k];
                e.mask[k] = 1'b1;
            end
            e.cnt = 4'(n);
            sbq.push_back(e);
            n = 0;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int w = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = last;
        while (!ifc.in_ready && w < 50) begin
            step();
            w++;
        end
        if (!ifc.in_ready) begin
            chk("send_ready_timeout", 64'(ifc.in_ready), 64'd1);
        end else begin
            step();
            model_push(d, last);
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 64'(ifc.out_valid), 64'd1);
        chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd0);
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd1);
        end else begin
            e = sbq.pop_front();
            hold_vec = e.vec;
            chk({tag, "_vec"}, ifc.out_vec, e.vec);
            chk({tag, "_mask"}, 64'(ifc.out_mask), 64'(e.mask));
            chk({tag, "_count"}, 64'(ifc.out_count), 64'(e.cnt));
        end
    endtask

    task automatic drain(input string tag);
        step();
        chk({tag, "_drain_valid"}, 64'(ifc.out_valid), 64'd0);
        chk({tag, "_drain_ready"}, 64'(ifc.in_ready), 64'd1);
        chk({tag, "_drain_vec"}, ifc.out_vec, 64'd0);
        chk({tag, "_drain_mask"}, 64'(ifc.out_mask), 64'd0);
        chk({tag, "_drain_count"}, 64'(ifc.out_count), 64'd0);
    endtask

    initial begin
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 8'h99;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;

        // Reset with in_valid asserted: nothing may be taken.
        step();
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
        step();
        chk("rst_vec", ifc.out_vec, 64'd0);
        chk("rst_mask", 64'(ifc.out_mask), 64'd0);
        chk("rst_count", 64'(ifc.out_count), 64'd0);
        chk("rst_valid", 64'(ifc.out_valid), 64'd0);
        ifc.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ifc.in_ready), 64'd1);

        // Full vector back-to-back.
        for (int i = 1; i <= 8; i++) begin
            send(8'(i * 8'h11), 1'b0);
            if (i < 8) chk("b2b_no_early_valid", 64'(ifc.out_valid), 64'd0);
        end
        chk("b2b_const", ifc.out_vec, 64'h8877665544332211);
        for (int k = 0; k < 8; k++) begin
            chk("lane_select", 64'(ifc.out_vec[k*8 +: 8]), 64'((k + 1) * 8'h11));
        end
        expect_out("b2b");
        drain("b2b");

        // Short vector closed by in_last.
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hC3, 1'b1);
        chk("short_const", ifc.out_vec, 64'h0000000000C3B2A1);
        expect_out("short");
        drain("short");

        // Backpressure while the next element is already offered.
        ifc.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i * 8'h11), 1'b0);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'hEE;
        expect_out("bp");
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_vec", ifc.out_vec, hold_vec);
            chk("bp_hold_ready", 64'(ifc.in_ready), 64'd0);
            chk("bp_hold_valid", 64'(ifc.out_valid), 64'd1);
        end
        ifc.out_ready = 1'b1;
        step();
        chk("bp_release_vec", ifc.out_vec, 64'd0);
        chk("bp_release_ready", 64'(ifc.in_ready), 64'd1);
        send(8'hEE, 1'b0);
        for (int i = 2; i <= 8; i++) send(8'(i), 1'b0);
        chk("bp_lane0", 64'(ifc.out_vec[7:0]), 64'hEE);
        expect_out("bp_next");
        drain("bp_next");

        // Gaps between elements; idle data must be ignored.
        for (int i = 1; i <= 8; i++) begin
            send(8'(i * 8'h11), 1'b0);
            if (i < 8) begin
                ifc.in_data = 8'h5A;
                step();
                step();
            end
        end
        chk("gap_const", ifc.out_vec, 64'h8877665544332211);
        expect_out("gap");
        drain("gap");

        // Reset mid-fill discards the partial vector.
        for (int i = 1; i <= 4; i++) send(8'(8'h40 + i), 1'b0);
        sbq.delete();
        rst = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h77;
        step();
        n = 0;
        chk("mid_rst_vec", ifc.out_vec, 64'd0);
        chk("mid_rst_mask", 64'(ifc.out_mask), 64'd0);
        chk("mid_rst_count", 64'(ifc.out_count), 64'd0);
        chk("mid_rst_valid", 64'(ifc.out_valid), 64'd0);
        chk("mid_rst_ready", 64'(ifc.in_ready), 64'd0);
        ifc.in_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("after_rst_valid", 64'(ifc.out_valid), 64'd0);
        chk("after_rst_ready", 64'(ifc.in_ready), 64'd1);
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        chk("rst_refill_const", ifc.out_vec, 64'h0807060504030201);
        expect_out("rst_refill");
        drain("rst_refill");

        // in_last on the final lane yields an ordinary full vector.
        for (int i = 1; i <= 8; i++) send(8'(8'hF0 + i), i == 8);
        chk("last_full_count", 64'(ifc.out_count), 64'd8);
        expect_out("last_full");
        drain("last_full");

        chk("sb_leftover", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
